lsq_mem_port_sched: RTL and testbench
=====================================

// Module: lsq_mem_port_sched
// PURPOSE
//  Schedules the single data-memory port between the load queue (load issue) and the store queue
//  (committed-store drain). Sits between lq/sq and data memory, and returns load data to the writeback stage.
//  Loads have priority unless the store queue is near full; in-flight loads are killed on flush.
// PARAMETERS
//  RD_LAT      2   memory read latency, cycles from mem_en (read) to mem_rdata valid; legal range 1..7
//  ST_HI_WM    6   sq_cnt at or above this value gives a pending store priority over a load
//  STARVE_MAX  4   consecutive load grants with st_req pending before a store is forced (macro only)
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst        in   1   synchronous reset, active-high
//  flsh       in   1   pipeline flush (mispredict); kills in-flight and not-yet-granted loads
//  ld_req     in   1   load queue has a load ready; held until ld_gnt
//  ld_addr    in   16  load address
//  ld_indx    in   6   load ROB index
//  ld_phy     in   6   load destination physical register
//  ld_gnt     out  1   one-cycle grant to load queue
//  st_req     in   1   store queue has a committed store ready; held until st_gnt
//  st_addr    in   16  store address
//  st_data    in   16  store data
//  sq_cnt     in   4   current store-queue occupancy
//  st_gnt     out  1   one-cycle grant to store queue
//  mem_en     out  1   memory access strobe
//  mem_we     out  1   1 = write, 0 = read; valid with mem_en
//  mem_addr   out  16  memory address
//  mem_wdata  out  16  memory write data
//  mem_rdata  in   16  memory read data, valid RD_LAT cycles after the read mem_en
//  wb_vld     out  1   load data valid to writeback / register write
//  wb_indx    out  6   ROB index of the returned load
//  wb_phy     out  6   destination physical register of the returned load
//  wb_data    out  16  returned load data
//  arb_state  out  2   state: 0 IDLE, 1 LD_WAIT, 2 ST_WR
// BEHAVIOUR
//  - All outputs are registered. On reset every output is 0, state is IDLE, and the kill flag,
//    latency counter and starve counter are cleared. Reset mid-access abandons the access: no wb_vld.
//  - Requests are sampled only in IDLE. A decision made in cycle t drives, in cycle t+1:
//    the gnt pulse, mem_en=1, mem_addr, mem_we, and mem_wdata. The gnt pulse and mem_en are coincident, one cycle.
//  - Priority in IDLE:
//      (1) st_req && sq_cnt>=ST_HI_WM -> store
//      (2) ld_req -> load
//      (3) st_req -> store
//      (4) none -> stay IDLE
//  - flsh high in IDLE: no load is granted that cycle. A store may still be granted (stores are committed).
//  - Store: IDLE -> ST_WR (gnt cycle) -> IDLE. Back-to-back stores are possible every 2 cycles.
//  - Load: IDLE -> LD_WAIT. The ld_indx and ld_phy of the load are captured at the decision.
//    Read mem_en is in cycle c. mem_rdata is captured at the end of c+RD_LAT.
//    wb_vld=1 in c+RD_LAT+1 for one cycle, and state returns to IDLE in that cycle.
//    The earliest next grant is c+RD_LAT+2.
//  - flsh in any cycle from c to c+RD_LAT sets kill. The state still waits the full latency; wb_vld stays 0.
//    Kill clears on return to IDLE.
//  - flsh during ST_WR has no effect on the write.
//  - wb_indx, wb_phy and wb_data hold their last values when wb_vld=0.
//  - sq_cnt is compared unsigned; wrap is not possible (4 bits, max queue depth 15).
// CONFIGURATION
//  ST_STARVE_GUARD_EN defined:
//    - A 3-bit counter increments on each load grant made while st_req=1, and clears on any store grant.
//    - When the counter reaches STARVE_MAX and st_req=1, the next IDLE decision grants the store,
//      overriding rule (2).
//  ST_STARVE_GUARD_EN undefined:
//    - No counter; stores win only through rules (1) and (3). STARVE_MAX is ignored.
// TESTING
//  1. Reset, then ld_req with addr=1, indx=5, phy=14 -> ld_gnt and mem_en at t+1 with we=0 and addr=1.
//     wb_vld at t+1+RD_LAT+1 with indx=5, phy=14, data=mem[1].
//  2. st_req with addr=0, data=16'haaaa -> st_gnt, mem_en, we=1 at t+1; arb_state 2 then 0;
//     a following load from addr 0 returns 16'haaaa.
//  3. ld_req and st_req together with sq_cnt=3 -> load granted first and the store after the load returns.
//     With sq_cnt=6 -> the store is granted first.
//  4. Load granted, flsh pulsed at c+1 -> no wb_vld, arb_state returns to 0 at c+RD_LAT+1, next request is granted normally.
//  5. flsh held high in IDLE with ld_req=1 and st_req=1 -> only the store is granted.
//     rst asserted during LD_WAIT -> all outputs 0 next cycle and no wb_vld.
//  6. ST_STARVE_GUARD_EN, continuous ld_req and st_req with sq_cnt=0 -> a store grant after every 4 load grants.
//     With the macro undefined -> no store grant until ld_req drops.

Source files
------------

// File: rtl/lsq_mem_port_sched.sv
// Single data-memory port scheduler between load issue and committed-store drain, with load writeback.
// Optional store-starvation guard is compiled in when ST_STARVE_GUARD_EN is defined.
module lsq_mem_port_sched #(
   parameter int RD_LAT     = 2,
   parameter int ST_HI_WM   = 6,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flsh,
   input  logic        ld_req,
   input  logic [15:0] ld_addr,
   input  logic [5:0]  ld_indx,
   input  logic [5:0]  ld_phy,
   output logic        ld_gnt,
   input  logic        st_req,
   input  logic [15:0] st_addr,
   input  logic [15:0] st_data,
   input  logic [3:0]  sq_cnt,
   output logic        st_gnt,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        wb_vld,
   output logic [5:0]  wb_indx,
   output logic [5:0]  wb_phy,
   output logic [15:0] wb_data,
   output logic [1:0]  arb_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  lat_cnt, lat_nxt;
   logic        kill, kill_nxt;
   logic [5:0]  tag_indx, tag_indx_nxt;
   logic [5:0]  tag_phy, tag_phy_nxt;

   logic        ld_gnt_nxt, st_gnt_nxt, mem_en_nxt, mem_we_nxt, wb_vld_nxt;
   logic [15:0] mem_addr_nxt, mem_wdata_nxt, wb_data_nxt;
   logic [5:0]  wb_indx_nxt, wb_phy_nxt;

   logic        st_hi, ld_ok, starve_force, grant_st, grant_ld, ld_dead;

`ifdef ST_STARVE_GUARD_EN
   logic [2:0]  starve_cnt, starve_nxt;
`endif

   assign arb_state = state;

   // Arbitration: high-watermark store, then (optionally) starved store, then load, then any store.
   always_comb begin
      st_hi = st_req && (int'(sq_cnt) >= ST_HI_WM);
      ld_ok = ld_req && !flsh;
`ifdef ST_STARVE_GUARD_EN
      starve_force = st_req && (int'(starve_cnt) >= STARVE_MAX);
`else
      starve_force = 1'b0;
`endif
      grant_st = st_hi || starve_force || (st_req && !ld_ok);
      grant_ld = ld_ok && !grant_st;
   end

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt     = state;
      lat_nxt       = lat_cnt;
      kill_nxt      = kill;
      tag_indx_nxt  = tag_indx;
      tag_phy_nxt   = tag_phy;
      ld_gnt_nxt    = 1'b0;
      st_gnt_nxt    = 1'b0;
      mem_en_nxt    = 1'b0;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      wb_vld_nxt    = 1'b0;
      wb_indx_nxt   = wb_indx;
      wb_phy_nxt    = wb_phy;
      wb_data_nxt   = wb_data;
      ld_dead       = kill || flsh;
`ifdef ST_STARVE_GUARD_EN
      starve_nxt    = starve_cnt;
`endif

      unique case (state)
         IDLE: begin
            kill_nxt = 1'b0;
            lat_nxt  = 3'd0;
            if (grant_st) begin
               state_nxt     = ST_WR;
               st_gnt_nxt    = 1'b1;
               mem_en_nxt    = 1'b1;
               mem_we_nxt    = 1'b1;
               mem_addr_nxt  = st_addr;
               mem_wdata_nxt = st_data;
`ifdef ST_STARVE_GUARD_EN
               starve_nxt    = 3'd0;
`endif
            end else if (grant_ld) begin
               state_nxt    = LD_WAIT;
               ld_gnt_nxt   = 1'b1;
               mem_en_nxt   = 1'b1;
               mem_we_nxt   = 1'b0;
               mem_addr_nxt = ld_addr;
               tag_indx_nxt = ld_indx;
               tag_phy_nxt  = ld_phy;
`ifdef ST_STARVE_GUARD_EN
               if (st_req && starve_cnt != 3'd7) starve_nxt = starve_cnt + 3'd1;
`endif
            end
         end

         // Waits the full latency even when killed so the returning read cannot collide with a new access.
         LD_WAIT: begin
            kill_nxt = ld_dead;
            if (int'(lat_cnt) == RD_LAT) begin
               state_nxt = IDLE;
               kill_nxt  = 1'b0;
               if (!ld_dead) begin
                  wb_vld_nxt  = 1'b1;
                  wb_indx_nxt = tag_indx;
                  wb_phy_nxt  = tag_phy;
                  wb_data_nxt = mem_rdata;
               end
            end else begin
               lat_nxt = lat_cnt + 3'd1;
            end
         end

         ST_WR: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_cnt   <= 3'd0;
         kill      <= 1'b0;
         tag_indx  <= 6'd0;
         tag_phy   <= 6'd0;
         ld_gnt    <= 1'b0;
         st_gnt    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 16'd0;
         mem_wdata <= 16'd0;
         wb_vld    <= 1'b0;
         wb_indx   <= 6'd0;
         wb_phy    <= 6'd0;
         wb_data   <= 16'd0;
`ifdef ST_STARVE_GUARD_EN
         starve_cnt <= 3'd0;
`endif
      end else begin
         state     <= state_nxt;
         lat_cnt   <= lat_nxt;
         kill      <= kill_nxt;
         tag_indx  <= tag_indx_nxt;
         tag_phy   <= tag_phy_nxt;
         ld_gnt    <= ld_gnt_nxt;
         st_gnt    <= st_gnt_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         wb_vld    <= wb_vld_nxt;
         wb_indx   <= wb_indx_nxt;
         wb_phy    <= wb_phy_nxt;
         wb_data   <= wb_data_nxt;
`ifdef ST_STARVE_GUARD_EN
         starve_cnt <= starve_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_lsq_mem_port_sched.sv
// Self-checking bench for lsq_mem_port_sched: cycle-indexed expectation model plus directed literal checks.
// Honours ST_STARVE_GUARD_EN the same way the design does.
module tb_lsq_mem_port_sched;

   localparam int RD_LAT     = 2;
   localparam int ST_HI_WM   = 6;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flsh = 1'b0;
   logic        ld_req = 1'b0;
   logic [15:0] ld_addr = '0;
   logic [5:0]  ld_indx = '0;
   logic [5:0]  ld_phy = '0;
   logic        st_req = 1'b0;
   logic [15:0] st_addr = '0;
   logic [15:0] st_data = '0;
   logic [3:0]  sq_cnt = '0;
   logic [15:0] mem_rdata = '0;
   logic        ld_gnt, st_gnt, mem_en, mem_we, wb_vld;
   logic [15:0] mem_addr, mem_wdata, wb_data;
   logic [5:0]  wb_indx, wb_phy;
   logic [1:0]  arb_state;

   lsq_mem_port_sched #(.RD_LAT(RD_LAT), .ST_HI_WM(ST_HI_WM), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst), .flsh(flsh),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_indx(ld_indx), .ld_phy(ld_phy), .ld_gnt(ld_gnt),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .sq_cnt(sq_cnt), .st_gnt(st_gnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .wb_vld(wb_vld), .wb_indx(wb_indx), .wb_phy(wb_phy), .wb_data(wb_data),
      .arb_state(arb_state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory environment: answers the DUT's actual read strobes exactly RD_LAT cycles later.
   logic [15:0] env_mem [16];
   logic [15:0] rd_dat  [16];
   logic        rd_v    [16];
   int          env_cyc = 0;

   always @(negedge clk) begin
      if (mem_en === 1'b1) begin
         if (mem_we) env_mem[mem_addr[3:0]] = mem_wdata;
         else begin
            rd_v[(env_cyc + RD_LAT) % 16]   = 1'b1;
            rd_dat[(env_cyc + RD_LAT) % 16] = env_mem[mem_addr[3:0]];
         end
      end
      mem_rdata = rd_v[env_cyc % 16] ? rd_dat[env_cyc % 16] : 16'($urandom);
      rd_v[env_cyc % 16] = 1'b0;
      env_cyc++;
   end

   // Reference model: per-cycle expected outputs in a ring indexed by absolute cycle number.
   typedef struct packed {
      logic        ld_gnt, st_gnt, mem_en, mem_we, wb_vld;
      logic [15:0] mem_addr, mem_wdata, wb_data;
      logic [5:0]  wb_indx, wb_phy;
      logic [1:0]  st;
   } exp_t;

   exp_t        expq [16];
   exp_t        e;
   logic [15:0] ref_mem [16];
   int          cyc = 0;
   int          free_at = 0;
   bit          model_on = 0;
   logic [5:0]  m_wb_indx, m_wb_phy;
   logic [15:0] m_wb_data;
   bit          ld_act, ld_kill;
   int          ld_c;
   logic [5:0]  ld_t_indx, ld_t_phy;
   logic [15:0] ld_t_data;
   int          starve = 0;

   always @(negedge clk) begin
      if (model_on) begin
         e = expq[cyc % 16];
         if (e.wb_vld) begin
            m_wb_indx = e.wb_indx;
            m_wb_phy  = e.wb_phy;
            m_wb_data = e.wb_data;
         end
         check("ld_gnt", ld_gnt, e.ld_gnt);
         check("st_gnt", st_gnt, e.st_gnt);
         check("mem_en", mem_en, e.mem_en);
         if (e.mem_en) begin
            check("mem_we", mem_we, e.mem_we);
            check("mem_addr", mem_addr, e.mem_addr);
            if (e.mem_we) check("mem_wdata", mem_wdata, e.mem_wdata);
         end
         check("wb_vld", wb_vld, e.wb_vld);
         check("wb_indx", wb_indx, m_wb_indx);
         check("wb_phy", wb_phy, m_wb_phy);
         check("wb_data", wb_data, m_wb_data);
         check("arb_state", arb_state, e.st);
      end
      expq[cyc % 16] = '0;

      if (rst) begin
         for (int i = 0; i < 16; i++) expq[i] = '0;
         model_on  = 1;
         m_wb_indx = '0;
         m_wb_phy  = '0;
         m_wb_data = '0;
         ld_act    = 0;
         starve    = 0;
         free_at   = cyc + 1;
      end else if (model_on) begin
         if (ld_act) begin
            if (flsh) ld_kill = 1;
            if (cyc == ld_c + RD_LAT) begin
               if (!ld_kill) begin
                  expq[(cyc + 1) % 16].wb_vld  = 1'b1;
                  expq[(cyc + 1) % 16].wb_indx = ld_t_indx;
                  expq[(cyc + 1) % 16].wb_phy  = ld_t_phy;
                  expq[(cyc + 1) % 16].wb_data = ld_t_data;
               end
               ld_act = 0;
            end
         end
         if (cyc >= free_at) begin
            bit take_st;
            take_st = st_req && ((int'(sq_cnt) >= ST_HI_WM) || !(ld_req && !flsh));
`ifdef ST_STARVE_GUARD_EN
            if (st_req && starve >= STARVE_MAX) take_st = 1;
`endif
            if (take_st) begin
               expq[(cyc + 1) % 16].st_gnt    = 1'b1;
               expq[(cyc + 1) % 16].mem_en    = 1'b1;
               expq[(cyc + 1) % 16].mem_we    = 1'b1;
               expq[(cyc + 1) % 16].mem_addr  = st_addr;
               expq[(cyc + 1) % 16].mem_wdata = st_data;
               expq[(cyc + 1) % 16].st        = 2'd2;
               ref_mem[st_addr[3:0]] = st_data;
               starve  = 0;
               free_at = cyc + 2;
            end else if (ld_req && !flsh) begin
               expq[(cyc + 1) % 16].ld_gnt   = 1'b1;
               expq[(cyc + 1) % 16].mem_en   = 1'b1;
               expq[(cyc + 1) % 16].mem_we   = 1'b0;
               expq[(cyc + 1) % 16].mem_addr = ld_addr;
               for (int k = 1; k <= RD_LAT + 1; k++) expq[(cyc + k) % 16].st = 2'd1;
               ld_act    = 1;
               ld_kill   = 0;
               ld_c      = cyc + 1;
               ld_t_indx = ld_indx;
               ld_t_phy  = ld_phy;
               ld_t_data = ref_mem[ld_addr[3:0]];
               if (st_req && starve < 7) starve++;
               free_at = cyc + RD_LAT + 2;
            end
         end
      end
      cyc++;
   end

   int n_ld, n_st, since;
   bit seen;

   initial begin
      for (int i = 0; i < 16; i++) begin
         env_mem[i] = 16'h1000 + 16'(i);
         ref_mem[i] = 16'h1000 + 16'(i);
         rd_v[i]    = 1'b0;
         expq[i]    = '0;
      end

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_ld_gnt", ld_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_wb_vld", wb_vld, 0);
      check("rst_arb_state", arb_state, 0);
      rst = 1'b0;

      // 1: basic load
      ld_req = 1; ld_addr = 16'd1; ld_indx = 6'd5; ld_phy = 6'd14;
      tick();
      check("t1_ld_gnt", ld_gnt, 1);
      check("t1_mem_en", mem_en, 1);
      check("t1_mem_we", mem_we, 0);
      check("t1_mem_addr", mem_addr, 16'd1);
      check("t1_state", arb_state, 1);
      ld_req = 0;
      repeat (RD_LAT + 1) tick();
      check("t1_wb_vld", wb_vld, 1);
      check("t1_wb_indx", wb_indx, 6'd5);
      check("t1_wb_phy", wb_phy, 6'd14);
      check("t1_wb_data", wb_data, 16'h1001);
      check("t1_state_back", arb_state, 0);

      // 2: store then load from the same address
      st_req = 1; st_addr = 16'd0; st_data = 16'haaaa; sq_cnt = 4'd0;
      tick();
      check("t2_st_gnt", st_gnt, 1);
      check("t2_mem_we", mem_we, 1);
      check("t2_mem_wdata", mem_wdata, 16'haaaa);
      check("t2_state", arb_state, 2);
      st_req = 0;
      tick();
      check("t2_state_idle", arb_state, 0);
      ld_req = 1; ld_addr = 16'd0; ld_indx = 6'd1; ld_phy = 6'd2;
      tick();
      check("t2_ld_gnt", ld_gnt, 1);
      ld_req = 0;
      repeat (RD_LAT + 1) tick();
      check("t2_wb_data", wb_data, 16'haaaa);

      // 3: priority with low and high store-queue occupancy
      ld_req = 1; ld_addr = 16'd3; ld_indx = 6'd3; ld_phy = 6'd4;
      st_req = 1; st_addr = 16'd4; st_data = 16'h1234; sq_cnt = 4'd3;
      tick();
      check("t3_ld_first", ld_gnt, 1);
      check("t3_st_not_first", st_gnt, 0);
      ld_req = 0;
      repeat (RD_LAT + 1) tick();
      check("t3_wb_vld", wb_vld, 1);
      check("t3_wb_data", wb_data, 16'h1003);
      tick();
      check("t3_st_after", st_gnt, 1);
      st_req = 0;
      tick();
      ld_req = 1; ld_addr = 16'd5; ld_indx = 6'd11; ld_phy = 6'd12;
      st_req = 1; st_addr = 16'd6; st_data = 16'h4321; sq_cnt = 4'd6;
      tick();
      check("t3_hi_st_first", st_gnt, 1);
      check("t3_hi_ld_wait", ld_gnt, 0);
      st_req = 0;
      repeat (2) tick();
      check("t3_hi_ld_next", ld_gnt, 1);
      ld_req = 0;
      repeat (RD_LAT + 1) tick();
      check("t3_hi_wb_data", wb_data, 16'h1005);

      // 4: flush kills an in-flight load
      ld_req = 1; ld_addr = 16'd7; ld_indx = 6'd9; ld_phy = 6'd10; sq_cnt = 4'd0;
      tick();
      check("t4_ld_gnt", ld_gnt, 1);
      ld_req = 0;
      tick();
      flsh = 1;
      tick();
      flsh = 0;
      repeat (RD_LAT - 1) tick();
      check("t4_no_wb", wb_vld, 0);
      check("t4_state_idle", arb_state, 0);
      check("t4_wb_indx_held", wb_indx, 6'd11);
      ld_req = 1; ld_addr = 16'd8; ld_indx = 6'd13; ld_phy = 6'd14;
      tick();
      check("t4_next_gnt", ld_gnt, 1);
      ld_req = 0;
      repeat (RD_LAT + 1) tick();
      check("t4_next_wb", wb_vld, 1);
      check("t4_next_data", wb_data, 16'h1008);

      // 5: flush in IDLE blocks only the load; reset during LD_WAIT
      flsh = 1;
      ld_req = 1; ld_addr = 16'd2; ld_indx = 6'd20; ld_phy = 6'd21;
      st_req = 1; st_addr = 16'd9; st_data = 16'h5555; sq_cnt = 4'd0;
      tick();
      check("t5_st_gnt", st_gnt, 1);
      check("t5_ld_blocked", ld_gnt, 0);
      st_req = 0;
      repeat (2) tick();
      check("t5_ld_still_blocked", ld_gnt, 0);
      flsh = 0;
      tick();
      check("t5_ld_gnt", ld_gnt, 1);
      ld_req = 0;
      rst = 1;
      tick();
      rst = 0;
      check("t5_rst_ld_gnt", ld_gnt, 0);
      check("t5_rst_mem_en", mem_en, 0);
      check("t5_rst_mem_addr", mem_addr, 0);
      check("t5_rst_wb_data", wb_data, 0);
      check("t5_rst_wb_indx", wb_indx, 0);
      check("t5_rst_state", arb_state, 0);
      for (int i = 0; i < RD_LAT + 2; i++) begin
         tick();
         check("t5_no_wb_after_rst", wb_vld, 0);
      end

      // 6: continuous loads with a pending low-priority store
      n_ld = 0; n_st = 0; since = 0; seen = 0;
      ld_req = 1; ld_addr = 16'd10; st_req = 1; st_addr = 16'd11; st_data = 16'h7777; sq_cnt = 4'd0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (ld_gnt) begin
            n_ld++;
            since++;
            ld_addr = 16'($urandom_range(0, 15));
         end
         if (st_gnt) begin
            n_st++;
`ifdef ST_STARVE_GUARD_EN
            check("t6_loads_between_stores", since, STARVE_MAX);
`endif
            since = 0;
         end
      end
`ifdef ST_STARVE_GUARD_EN
      check("t6_store_count", n_st >= 3, 1);
`else
      check("t6_no_store", n_st, 0);
      check("t6_loads_flowed", n_ld > 10, 1);
      ld_req = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         tick();
         if (st_gnt) seen = 1;
      end
      check("t6_store_after_ld_drop", seen, 1);
`endif
      ld_req = 0; st_req = 0;
      repeat (RD_LAT + 3) tick();

      // Randomized traffic under the request/hold protocol
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (ld_gnt) ld_req = 0;
         if (st_gnt) st_req = 0;
         if (!ld_req && $urandom_range(0, 2) == 0) begin
            ld_req  = 1;
            ld_addr = 16'($urandom_range(0, 15));
            ld_indx = 6'($urandom);
            ld_phy  = 6'($urandom);
         end
         if (!st_req && $urandom_range(0, 3) == 0) begin
            st_req  = 1;
            st_addr = 16'($urandom_range(0, 15));
            st_data = 16'($urandom);
         end
         sq_cnt = 4'($urandom_range(0, 15));
         flsh   = ($urandom_range(0, 7) == 0);
         rst    = ($urandom_range(0, 199) == 0);
      end
      rst = 0; flsh = 0; ld_req = 0; st_req = 0;
      repeat (RD_LAT + 4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
